// File: rtl/dice_turn_scheduler_if.sv
// Bundle of player-side and game-controller-side signals for the dice turn
// scheduler. The scheduler takes the slave view; the stimulus/board side
// takes the master view.
interface dice_turn_scheduler_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int PID_W       = 2,
  parameter int CNT_W       = 4
);
  logic [NUM_PLAYERS-1:0]       roll_btn;
  logic                         new_match;
  logic                         game_win;
  logic                         game_lose;
  logic                         game_x;
  logic                         game_reset_n;
  logic [PID_W-1:0]             active_player;
  logic [NUM_PLAYERS*CNT_W-1:0] score;
  logic                         match_done;
  logic [PID_W-1:0]             champion;

  modport master (
    output roll_btn, new_match, game_win, game_lose,
    input  game_x, game_reset_n, active_player, score, match_done, champion
  );

  modport slave (
    input  roll_btn, new_match, game_win, game_lose,
    output game_x, game_reset_n, active_player, score, match_done, champion
  );
endinterface

// File: rtl/dice_turn_scheduler.sv
// Round-robin turn scheduler that shares one dice game controller among
// NUM_PLAYERS players, keeps a saturating win count per player and declares
// a champion once a player reaches WIN_TARGET wins.
module dice_turn_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int PID_W       = 2,
  parameter int CNT_W       = 4,
  parameter int WIN_TARGET  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  dice_turn_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_PLAY,
    S_RESULT,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] WIN_CNT     = CNT_W'(WIN_TARGET);
  localparam logic [PID_W-1:0] LAST_PLAYER = PID_W'(NUM_PLAYERS - 1);

  state_t           state_q;
  logic [PID_W-1:0] active_q;
  logic [PID_W-1:0] champion_q;
  logic [CNT_W-1:0] score_q [NUM_PLAYERS];

  logic             active_btn;
  logic [PID_W-1:0] next_player;
  logic             game_x_d;
  logic             game_reset_n_d;
  logic             match_done_d;

  // Only the active player's button is ever looked at.
  assign active_btn  = bus.roll_btn[active_q];
  assign next_player = (active_q == LAST_PLAYER) ? '0 : active_q + PID_W'(1);

  // Turn sequencing, score keeping and champion latching.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      active_q   <= '0;
      champion_q <= '0;
      // NOTE: the score array is a handful of flops, not a RAM, so it is
      // safe (and required) to clear it in the reset branch.
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      case (state_q)
        S_CLEAR: state_q <= S_PLAY;
        S_PLAY: begin
          if (bus.game_lose) begin
            state_q <= S_RESULT;
          end else if (bus.game_win) begin
            if (score_q[active_q] != CNT_MAX)
              score_q[active_q] <= score_q[active_q] + CNT_W'(1);
            state_q <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (score_q[active_q] == WIN_CNT) begin
            champion_q <= active_q;
            state_q    <= S_DONE;
          end else begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!active_btn) begin
            active_q <= next_player;
            state_q  <= S_CLEAR;
          end
        end
        S_DONE: begin
          if (bus.new_match) begin
            for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
            active_q   <= '0;
            champion_q <= '0;
            state_q    <= S_CLEAR;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Output decode from the registered state; game_x passes the button through.
  // NOTE: every output gets a default first so no latch can be inferred.
  always_comb begin
    game_x_d       = 1'b0;
    game_reset_n_d = 1'b0;
    match_done_d   = 1'b0;
    case (state_q)
      S_PLAY, S_RESULT, S_RELEASE: begin
        game_reset_n_d = 1'b1;
        game_x_d       = active_btn;
      end
      S_DONE:  match_done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.game_x        = game_x_d;
  assign bus.game_reset_n  = game_reset_n_d;
  assign bus.match_done    = match_done_d;
  assign bus.active_player = active_q;
  assign bus.champion      = champion_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign bus.score[g*CNT_W +: CNT_W] = score_q[g];
  end

endmodule

// File: doc/dice_turn_scheduler.md
Name: dice_turn_scheduler

Overview:
- Shares one dice game datapath and its game controller among NUM_PLAYERS players in strict round-robin turns.
- Forwards only the active player's roll button to the game controller as its roll input.
- Resets the game controller between turns and keeps a saturating win count per player.
- Declares a champion when any player's win count reaches WIN_TARGET.

Parameters:
NUM_PLAYERS, 4, number of players; 2 <= NUM_PLAYERS <= 2**PID_W
PID_W, 2, width of player index
CNT_W, 4, width of each per-player win counter
WIN_TARGET, 3, wins needed to end the match; 1 <= WIN_TARGET <= 2**CNT_W-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
roll_btn  in  NUM_PLAYERS  per-player roll level, already synchronized to clk
new_match  in  1  single-cycle pulse; honoured only in DONE
game_win  in  1  win flag from game controller
game_lose  in  1  lose flag from game controller
game_x  out  1  roll input to game controller
game_reset_n  out  1  active-low reset to game controller
active_player  out  PID_W  index of the player whose turn it is
score  out  NUM_PLAYERS*CNT_W  packed win counters; player i occupies bits [i*CNT_W +: CNT_W]
match_done  out  1  high while in DONE
champion  out  PID_W  winning player index; valid while match_done=1

Behaviour:
- Outputs at reset: state=CLEAR, active_player=0, all scores=0, game_x=0, game_reset_n=0, match_done=0, champion=0.
- Reset asserted mid-operation aborts the turn immediately; no score update occurs.
- FSM states: CLEAR, PLAY, RESULT, RELEASE, DONE. State is registered; outputs are decoded from state, except game_x.
- CLEAR:
  - game_reset_n=0, game_x=0.
  - Lasts exactly one cycle, then goes to PLAY.
- PLAY:
  - game_reset_n=1; game_x = roll_btn[active_player] (combinational pass-through).
  - roll_btn bits of other players are ignored.
  - game_win=1 and game_lose=0 at a clock edge: score[active_player] increments on that edge (saturating at 2**CNT_W-1); go to RESULT.
  - game_lose=1 (with or without game_win): treated as a loss; no score change; go to RESULT.
  - Otherwise stay in PLAY. There is no timeout.
- RESULT (one cycle):
  - game_x = roll_btn[active_player].
  - If score[active_player] == WIN_TARGET: latch champion=active_player and go to DONE.
  - Otherwise go to RELEASE.
- RELEASE:
  - game_x = roll_btn[active_player], so the game controller sees the button release.
  - When roll_btn[active_player]==0: active_player = (active_player+1) mod NUM_PLAYERS, wrapping from NUM_PLAYERS-1 to 0; go to CLEAR.
- DONE:
  - match_done=1, game_x=0, game_reset_n=0. All roll_btn bits are ignored.
  - Scores and champion are held.
  - new_match=1: clear all scores, active_player=0, champion=0; go to CLEAR.
  - new_match in any other state is ignored.
- Turn latency:
  - Win sampled at edge t: score visible after t.
  - Earliest next-player game_reset_n low is at edge t+2 (button already released).
- Score arithmetic: unsigned, CNT_W bits, never wraps.
- Player indices >= NUM_PLAYERS are unreachable.

Test Plan:
- Reset, then hold roll_btn=4'b0010 with active_player=0 -> game_x stays 0. Then set roll_btn=4'b0001 -> game_x=1 in the same cycle.
- Player 0 gets game_win pulse; release button -> score[0]=1; RESULT, RELEASE and CLEAR each seen for at least one cycle; active_player=1; game_reset_n low for exactly one cycle.
- game_win and game_lose asserted together for player 2 -> score[2] unchanged; turn advances to 3. Next turn ends -> active_player wraps to 0.
- Player 1 wins 3 times (WIN_TARGET=3) across rounds -> match_done=1, champion=1, score[1]=3. Subsequent roll_btn and game_win are ignored. new_match pulse -> all scores 0, active_player=0, match_done=0.
- Player holds roll_btn for 20 cycles after a loss -> scheduler stays in RELEASE and game_x stays 1; advances exactly 2 cycles after release.
- Assert reset in PLAY one cycle before game_win -> all scores 0, state CLEAR, game_reset_n=0 immediately (asynchronous).
